// File: rtl/vga_timing_gen_pkg.sv
// Default 640x480@60Hz raster constants and the coordinate type shared by
// the VGA timing generator and its consumers.
package vga_timing_pkg;

   localparam int unsigned H_VISIBLE_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;
   localparam int unsigned V_VISIBLE_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;

   localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   typedef logic [9:0] coord_t;

   function automatic coord_t to_coord(input int unsigned v);
      return coord_t'(v);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator drives it (master), renderers and the
// DAC path observe it (slave).
interface vga_timing_gen_if
   import vga_timing_pkg::*;
#(
   parameter int unsigned FRAME_CNT_W = 16
);
   coord_t                 DrawX;
   coord_t                 DrawY;
   logic                   blank;
   logic                   hs;
   logic                   vs;
   logic                   line_start;
   logic                   frame_start;
   logic [FRAME_CNT_W-1:0] frame_count;

   modport master (
      output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
   );

   modport slave (
      input DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
   );
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// DEPTH-stage 1-bit shift register with async reset to RESET_VAL; DEPTH=0
// degenerates to a plain wire.
module sync_delay_line #(
   parameter int unsigned DEPTH     = 1,
   parameter logic        RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign q = d;
      end else begin : g_shift
         logic [DEPTH-1:0] sr;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sr <= {DEPTH{RESET_VAL}};
            end else begin
               sr[0] <= d;
               for (int unsigned i = 1; i < DEPTH; i++) begin
                  sr[i] <= sr[i-1];
               end
            end
         end

         assign q = sr[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing source: pixel/line counters, registered
// blank/sync/strobe decode, delayed syncs and a frame counter.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
   parameter int unsigned H_FRONT     = H_FRONT_DEF,
   parameter int unsigned H_SYNC      = H_SYNC_DEF,
   parameter int unsigned H_BACK      = H_BACK_DEF,
   parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
   parameter int unsigned V_FRONT     = V_FRONT_DEF,
   parameter int unsigned V_SYNC      = V_SYNC_DEF,
   parameter int unsigned V_BACK      = V_BACK_DEF,
   parameter int unsigned SYNC_DELAY  = 1,
   parameter int unsigned FRAME_CNT_W = 16
) (
   input logic              vga_clk,
   input logic              reset,
   vga_timing_gen_if.master vga
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t X_LAST   = to_coord(H_TOTAL - 1);
   localparam coord_t Y_LAST   = to_coord(V_TOTAL - 1);
   localparam coord_t X_VIS    = to_coord(H_VISIBLE);
   localparam coord_t Y_VIS    = to_coord(V_VISIBLE);
   localparam coord_t HS_BEGIN = to_coord(H_VISIBLE + H_FRONT);
   localparam coord_t HS_END   = to_coord(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t VS_BEGIN = to_coord(V_VISIBLE + V_FRONT);
   localparam coord_t VS_END   = to_coord(V_VISIBLE + V_FRONT + V_SYNC);

   coord_t                 x, y, x_next, y_next;
   logic                   blank, line_start, frame_start;
   logic                   hs_raw, vs_raw, first_frame;
   logic [FRAME_CNT_W-1:0] fcount;
   logic                   wrap;

   always_comb begin
      x_next = x + 10'd1;
      y_next = y;
      if (x == X_LAST) begin
         x_next = '0;
         if (y == Y_LAST) y_next = '0;
         else             y_next = y + 10'd1;
      end
   end

   assign wrap = (x == X_LAST) && (y == Y_LAST);

   // Decode from the next-state counters so every flag lines up with DrawX/DrawY.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         x           <= X_LAST;
         y           <= Y_LAST;
         blank       <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         hs_raw      <= 1'b1;
         vs_raw      <= 1'b1;
         first_frame <= 1'b1;
         fcount      <= '0;
      end else begin
         x           <= x_next;
         y           <= y_next;
         blank       <= (x_next < X_VIS) && (y_next < Y_VIS);
         line_start  <= (x_next == '0);
         frame_start <= (x_next == '0) && (y_next == '0);
         hs_raw      <= !((x_next >= HS_BEGIN) && (x_next < HS_END));
         vs_raw      <= !((y_next >= VS_BEGIN) && (y_next < VS_END));
         if (wrap) begin
            if (first_frame) first_frame <= 1'b0;
            else             fcount      <= fcount + 1'b1;
         end
      end
   end

   sync_delay_line #(.DEPTH(SYNC_DELAY), .RESET_VAL(1'b1)) u_hs_delay (
      .clk (vga_clk),
      .rst (reset),
      .d   (hs_raw),
      .q   (vga.hs)
   );

   sync_delay_line #(.DEPTH(SYNC_DELAY), .RESET_VAL(1'b1)) u_vs_delay (
      .clk (vga_clk),
      .rst (reset),
      .d   (vs_raw),
      .q   (vga.vs)
   );

   assign vga.DrawX       = x;
   assign vga.DrawY       = y;
   assign vga.blank       = blank;
   assign vga.line_start  = line_start;
   assign vga.frame_start = frame_start;
   assign vga.frame_count = fcount;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing with 1- and
// 0-stage sync delay, plus a tiny raster with 2-bit frame counter).
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   typedef struct {
      int unsigned hv, hf, hs, hb, vv, vf, vs, vb, d, w;
   } cfg_t;

   typedef struct {
      int unsigned x, y, fc;
      bit          blank, hs, vs, ls, fs;
   } exp_t;

   logic clk;
   logic rst_a, rst_b, rst_c;
   int unsigned t_a, t_b, t_c;
   int n_checks = 0;
   int n_fail   = 0;

   cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 16};
   cfg_t cfg_b = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 16};
   cfg_t cfg_c = '{16, 2, 4, 2, 6, 1, 2, 1, 2, 2};

   vga_timing_gen_if #(.FRAME_CNT_W(16)) if_a ();
   vga_timing_gen_if #(.FRAME_CNT_W(16)) if_b ();
   vga_timing_gen_if #(.FRAME_CNT_W(2))  if_c ();

   vga_timing_gen #(.SYNC_DELAY(1), .FRAME_CNT_W(16)) dut_a (
      .vga_clk (clk), .reset (rst_a), .vga (if_a)
   );

   vga_timing_gen #(.SYNC_DELAY(0), .FRAME_CNT_W(16)) dut_b (
      .vga_clk (clk), .reset (rst_b), .vga (if_b)
   );

   vga_timing_gen #(
      .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (2),
      .V_VISIBLE (6),  .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
      .SYNC_DELAY (2), .FRAME_CNT_W (2)
   ) dut_c (
      .vga_clk (clk), .reset (rst_c), .vga (if_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges seen by each DUT since its reset was last released.
   always @(posedge clk) begin
      t_a <= rst_a ? 0 : t_a + 1;
      t_b <= rst_b ? 0 : t_b + 1;
      t_c <= rst_c ? 0 : t_c + 1;
   end

   function automatic bit in_sync(input int unsigned p, input int unsigned vis,
                                  input int unsigned fr, input int unsigned sw);
      return (p >= vis + fr) && (p < vis + fr + sw);
   endfunction

   // Position is a closed-form function of the edge count t since release.
   function automatic exp_t model(input cfg_t c, input int unsigned t);
      exp_t e;
      int unsigned ht, vt, fl, pos, sp;
      ht = c.hv + c.hf + c.hs + c.hb;
      vt = c.vv + c.vf + c.vs + c.vb;
      fl = ht * vt;
      e.hs = 1'b1;
      e.vs = 1'b1;
      if (t == 0) begin
         e.x = ht - 1; e.y = vt - 1; e.blank = 1'b0;
         e.ls = 1'b0;  e.fs = 1'b0;  e.fc = 0;
         return e;
      end
      pos     = (t - 1) % fl;
      e.x     = pos % ht;
      e.y     = pos / ht;
      e.blank = (e.x < c.hv) && (e.y < c.vv);
      e.ls    = (e.x == 0);
      e.fs    = (pos == 0);
      e.fc    = ((t - 1) / fl) % (32'd1 << c.w);
      if (t > c.d) begin
         sp   = (t - c.d - 1) % fl;
         e.hs = !in_sync(sp % ht, c.hv, c.hf, c.hs);
         e.vs = !in_sync(sp / ht, c.vv, c.vf, c.vs);
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_dut(input string p, input cfg_t c, input int unsigned t, input logic r,
                            input coord_t x, input coord_t y, input logic bl, input logic hs,
                            input logic vs, input logic ls, input logic fs, input logic [15:0] fc);
      exp_t e;
      e = model(c, r ? 0 : t);
      chk({p, ".DrawX"}, 32'(x), e.x);
      chk({p, ".DrawY"}, 32'(y), e.y);
      chk({p, ".blank"}, 32'(bl), 32'(e.blank));
      chk({p, ".hs"}, 32'(hs), 32'(e.hs));
      chk({p, ".vs"}, 32'(vs), 32'(e.vs));
      chk({p, ".line_start"}, 32'(ls), 32'(e.ls));
      chk({p, ".frame_start"}, 32'(fs), 32'(e.fs));
      chk({p, ".frame_count"}, 32'(fc), e.fc);
   endtask

   always @(negedge clk) begin
      check_dut("a", cfg_a, t_a, rst_a, if_a.DrawX, if_a.DrawY, if_a.blank, if_a.hs, if_a.vs,
                if_a.line_start, if_a.frame_start, if_a.frame_count);
      check_dut("b", cfg_b, t_b, rst_b, if_b.DrawX, if_b.DrawY, if_b.blank, if_b.hs, if_b.vs,
                if_b.line_start, if_b.frame_start, if_b.frame_count);
      check_dut("c", cfg_c, t_c, rst_c, if_c.DrawX, if_c.DrawY, if_c.blank, if_c.hs, if_c.vs,
                if_c.line_start, if_c.frame_start, 16'(if_c.frame_count));
   end

   int   vs_low_c = 0;
   int   fc_q[$];

   always @(negedge clk) begin
      if (!rst_c && t_c >= 1 && t_c <= 480 && !if_c.vs) vs_low_c++;
      if (!rst_c && if_c.frame_start && fc_q.size() < 5) fc_q.push_back(int'(if_c.frame_count));
   end

   task automatic check_first_cycle(input string p);
      chk({p, ".DrawX"}, 32'(if_a.DrawX), 0);
      chk({p, ".DrawY"}, 32'(if_a.DrawY), 0);
      chk({p, ".blank"}, 32'(if_a.blank), 1);
      chk({p, ".frame_start"}, 32'(if_a.frame_start), 1);
      chk({p, ".line_start"}, 32'(if_a.line_start), 1);
      chk({p, ".frame_count"}, 32'(if_a.frame_count), 0);
   endtask

   initial begin
      int hs_low_b, blank_b, first_a, first_b, n, sel, hold;
      int exp_fc[5] = '{0, 1, 2, 3, 0};
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      repeat (5) @(posedge clk);
      #3;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      @(posedge clk); #1;
      check_first_cycle("t1");

      hs_low_b = 0; blank_b = 0; first_a = -1; first_b = -1;
      for (int i = 0; i < 800; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         if (!if_b.hs) begin
            hs_low_b++;
            if (first_b < 0) first_b = int'(if_b.DrawX);
         end
         if (!if_a.hs && first_a < 0) first_a = int'(if_a.DrawX);
         if (if_b.blank) blank_b++;
      end
      chk("line0.hs_low_cycles_d0", 32'(hs_low_b), 96);
      chk("line0.hs_first_low_x_d0", 32'(first_b), 656);
      chk("line0.hs_first_low_x_d1", 32'(first_a), 657);
      chk("line0.visible_cycles", 32'(blank_b), 640);

      n = 0;
      while (!(if_a.DrawX == 10'd299 && if_a.DrawY == 10'd2) && n < 5000) begin
         @(posedge clk); #1; n++;
      end
      chk("midframe.reach_x", 32'(if_a.DrawX), 299);
      @(posedge clk);
      #3 rst_a = 1'b1;
      #1;
      chk("async_rst.DrawX", 32'(if_a.DrawX), 799);
      chk("async_rst.DrawY", 32'(if_a.DrawY), 524);
      chk("async_rst.hs", 32'(if_a.hs), 1);
      chk("async_rst.vs", 32'(if_a.vs), 1);
      chk("async_rst.blank", 32'(if_a.blank), 0);
      hold = int'($urandom_range(1, 8));
      repeat (hold) @(posedge clk);
      #3 rst_a = 1'b0;
      @(posedge clk); #1;
      check_first_cycle("t5");

      n = 0;
      while (fc_q.size() < 5 && n < 3000) begin @(posedge clk); n++; end
      chk("c.frames_seen", 32'(fc_q.size()), 5);
      for (int i = 0; i < fc_q.size(); i++) chk($sformatf("c.frame_count[%0d]", i), 32'(fc_q[i]), 32'(exp_fc[i]));
      chk("c.vs_low_cycles_2frames", 32'(vs_low_c), 96);

      // Random asynchronous resets at random phases, checked by the model process.
      repeat (6) begin
         sel  = int'($urandom_range(0, 2));
         repeat ($urandom_range(1, 1500)) @(posedge clk);
         #($urandom_range(1, 4));
         case (sel)
            0:       rst_a = 1'b1;
            1:       rst_b = 1'b1;
            default: rst_c = 1'b1;
         endcase
         repeat ($urandom_range(1, 6)) @(posedge clk);
         #($urandom_range(1, 4));
         rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      end
      repeat (500) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
